load_store_unit: RTL and testbench

- Sits between the processor core's data-memory port and the data memory or peripheral bus.
- Sequences each core load/store into a req/ready memory handshake.
- Generates the core's stall, byte enables, store-data replication, and load alignment/sign-extension.
- Bounds every access with a wait-state timeout that reports a bus fault.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/load_store_unit_if.sv | 37 +++
 rtl/lsu_data_align.sv | 66 ++++++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
//==============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit:
//               access-size encodings, FSM state type and fault causes.
// Revision    : 1.0 - initial release
//==============================================================================
package lsu_pkg;

    // Core access-size encodings; bit 2 selects zero-extension on loads.
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Why the access was aborted.
    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd1;
    localparam logic [1:0] FAULT_MISALIGN = 2'd2;

    // Halfword accesses need an even address, word accesses (including the
    // unused encodings that behave as words) need a word-aligned address.
    function automatic logic is_misaligned(input logic [2:0] size,
                                           input logic [1:0] off);
        logic r;
        r = 1'b0;
        case (size)
            LDST_B, LDST_BU: r = 1'b0;
            LDST_H, LDST_HU: r = off[0];
            default:         r = (off != 2'b00);
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
//==============================================================================
// Module      : load_store_unit_if
// Description : Word-wide data-memory request/ready bus between the load/store
//               unit (master) and the memory or peripheral fabric (slave).
// Revision    : 1.0 - initial release
//==============================================================================
interface load_store_unit_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_be_o,
        output mem_addr_o,
        output mem_wd_o,
        input  mem_rd_i,
        input  mem_ready_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_be_o,
        input  mem_addr_o,
        input  mem_wd_o,
        output mem_rd_i,
        output mem_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/lsu_data_align.sv
`default_nettype none
//==============================================================================
// Module      : lsu_data_align
// Description : Combinational lane steering. Store side: byte enables and
//               store-data replication. Load side: byte/half extraction with
//               sign or zero extension from a full memory word.
// Revision    : 1.0 - initial release
//==============================================================================
module lsu_data_align
    import lsu_pkg::*;
(
    input  wire logic [2:0]  i_st_size,
    input  wire logic [1:0]  i_st_off,
    input  wire logic [31:0] i_wd,
    input  wire logic [2:0]  i_ld_size,
    input  wire logic [1:0]  i_ld_off,
    input  wire logic [31:0] i_rd_word,
    output logic      [3:0]  o_be,
    output logic      [31:0] o_wd,
    output logic      [31:0] o_rd
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte enables and replicated store data for the outgoing request.
    always_comb begin
        o_be = 4'b1111;
        o_wd = i_wd;
        case (i_st_size)
            LDST_B, LDST_BU: begin
                o_be = 4'b0001 << i_st_off;
                o_wd = {4{i_wd[7:0]}};
            end
            LDST_H, LDST_HU: begin
                o_be = 4'b0011 << {i_st_off[1], 1'b0};
                o_wd = {2{i_wd[15:0]}};
            end
            default: begin
                o_be = 4'b1111;
                o_wd = i_wd;
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        w_byte = i_rd_word[7:0];
        case (i_ld_off)
            2'd0:    w_byte = i_rd_word[7:0];
            2'd1:    w_byte = i_rd_word[15:8];
            2'd2:    w_byte = i_rd_word[23:16];
            default: w_byte = i_rd_word[31:24];
        endcase
        w_half = i_ld_off[1] ? i_rd_word[31:16] : i_rd_word[15:0];
        case (i_ld_size)
            LDST_B:  o_rd = {{24{w_byte[7]}}, w_byte};
            LDST_BU: o_rd = {24'h0, w_byte};
            LDST_H:  o_rd = {{16{w_half[15]}}, w_half};
            LDST_HU: o_rd = {16'h0, w_half};
            default: o_rd = i_rd_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
//==============================================================================
// Module      : load_store_unit
// Description : Turns core loads/stores into a req/ready memory handshake,
//               stalls the core until the access commits, steers byte lanes
//               and aborts any access that waits longer than TIMEOUT_CYCLES.
//               Optional: define MISALIGN_CHECK_EN to fault misaligned H/W
//               accesses without issuing them to memory.
// Revision    : 1.0 - initial release
//==============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    input  wire logic        core_req_i,
    input  wire logic        core_we_i,
    input  wire logic [2:0]  core_size_i,
    input  wire logic [31:0] core_addr_i,
    input  wire logic [31:0] core_wd_i,
    output logic      [31:0] core_rd_o,
    output logic             core_stall_o,
    output logic             core_fault_o,
    load_store_unit_if.master mem
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       r_state;
    lsu_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic [1:0]       r_off;
    logic [2:0]       r_size;
    logic             r_we;
    logic [1:0]       r_cause;

    logic             w_req;
    logic             w_stall;
    logic             w_cap_req;
    logic             w_cap_rd;
    logic             w_cnt_inc;
    logic [1:0]       w_next_cause;
    logic             w_misaligned;
    logic [3:0]       w_be;
    logic [31:0]      w_wd;
    logic [31:0]      w_ld;

`ifdef MISALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(core_size_i, core_addr_i[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    lsu_data_align u_align (
        .i_st_size (core_size_i),
        .i_st_off  (core_addr_i[1:0]),
        .i_wd      (core_wd_i),
        .i_ld_size (r_size),
        .i_ld_off  (r_off),
        .i_rd_word (r_rdata),
        .o_be      (w_be),
        .o_wd      (w_wd),
        .o_rd      (w_ld)
    );

    // Next-state, handshake and capture-enable decode.
    always_comb begin
        w_next       = r_state;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        w_cap_req    = 1'b0;
        w_cap_rd     = 1'b0;
        w_cnt_inc    = 1'b0;
        w_next_cause = r_cause;
        case (r_state)
            IDLE: begin
                if (core_req_i) begin
                    w_stall   = 1'b1;
                    w_cap_req = 1'b1;
                    if (w_misaligned) begin
                        w_next_cause = FAULT_MISALIGN;
                        w_next       = DONE;
                    end else begin
                        w_req        = 1'b1;
                        w_next_cause = FAULT_NONE;
                        if (mem.mem_ready_i) begin
                            w_cap_rd = 1'b1;
                            w_next   = DONE;
                        end else begin
                            w_next = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                w_req     = 1'b1;
                w_stall   = 1'b1;
                w_cnt_inc = 1'b1;
                // A completing memory wins over an expiring timeout.
                if (mem.mem_ready_i) begin
                    w_cap_rd = 1'b1;
                    w_next   = DONE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_next_cause = FAULT_TIMEOUT;
                    w_next       = DONE;
                end
            end
            DONE: begin
                w_next_cause = FAULT_NONE;
                w_next       = IDLE;
            end
            default: begin
                w_next_cause = FAULT_NONE;
                w_next       = IDLE;
            end
        endcase
    end

    // State, wait counter and captured access attributes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_off   <= '0;
            r_size  <= '0;
            r_we    <= 1'b0;
            r_cause <= FAULT_NONE;
        end else begin
            r_state <= w_next;
            r_cause <= w_next_cause;
            if (w_cap_req) begin
                r_off  <= core_addr_i[1:0];
                r_size <= core_size_i;
                r_we   <= core_we_i;
                r_cnt  <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_cap_rd) begin
                r_rdata <= mem.mem_rd_i;
            end
        end
    end

    // Reset gates the handshake outputs so they drop without waiting for clk.
    assign mem.mem_req_o  = rst_ni & w_req;
    assign core_stall_o   = rst_ni & w_stall;

    assign mem.mem_we_o   = mem.mem_req_o ? core_we_i : 1'b0;
    assign mem.mem_be_o   = mem.mem_req_o ? w_be : 4'h0;
    assign mem.mem_addr_o = mem.mem_req_o ? {core_addr_i[31:2], 2'b00} : 32'h0;
    assign mem.mem_wd_o   = mem.mem_req_o ? w_wd : 32'h0;

    assign core_fault_o   = (r_state == DONE) && (r_cause != FAULT_NONE);
    assign core_rd_o      = ((r_state == DONE) && (r_cause == FAULT_NONE) && !r_we)
                            ? w_ld : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               four-cycle wait timeout.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_size = 3'd0;
    logic [31:0] core_addr = 32'h0;
    logic [31:0] core_wd = 32'h0;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        core_fault;

    load_store_unit_if mem_bus ();

    load_store_unit #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd),
        .core_stall_o (core_stall),
        .core_fault_o (core_fault),
        .mem          (mem_bus.master)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    int          a_stalls;
    int          a_reqs;
    int          a_faults;
    logic [31:0] a_rd;
    logic [31:0] a_be;
    logic [31:0] a_wd;
    logic [31:0] a_addr;
    logic [31:0] a_we;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One core access from IDLE; ready_at is the cycle index (0 = request
    // cycle) in which memory answers, -1 for never.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] word, input int ready_at);
        bit done;
        done     = 1'b0;
        a_stalls = 0;
        a_reqs   = 0;
        a_faults = 0;
        a_rd     = 32'hxxxx_xxxx;
        @(posedge clk); #1;
        core_req  = 1'b1;
        core_we   = we;
        core_size = size;
        core_addr = addr;
        core_wd   = wd;
        mem_bus.mem_rd_i = word;
        for (int i = 0; i < 20 && !done; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            mem_bus.mem_ready_i = (i == ready_at);
            @(negedge clk);
            if (i == 0) begin
                a_be   = {28'h0, mem_bus.mem_be_o};
                a_wd   = mem_bus.mem_wd_o;
                a_addr = mem_bus.mem_addr_o;
                a_we   = {31'h0, mem_bus.mem_we_o};
            end
            if (mem_bus.mem_req_o) a_reqs++;
            if (core_fault) a_faults++;
            if (core_stall) a_stalls++;
            else begin
                a_rd = core_rd;
                done = 1'b1;
            end
        end
        if (!done) a_stalls = 999;
        @(posedge clk); #1;
        core_req  = 1'b0;
        core_we   = 1'b0;
        core_size = 3'd0;
        core_addr = 32'h0;
        core_wd   = 32'h0;
        mem_bus.mem_ready_i = 1'b0;
        mem_bus.mem_rd_i    = 32'h0;
        @(negedge clk);
        if (core_fault) a_faults++;
    endtask

    initial begin
        mem_bus.mem_rd_i    = 32'h0;
        mem_bus.mem_ready_i = 1'b0;

        // Reset state
        #12;
        check("rst_stall",   {31'h0, core_stall}, 32'h0);
        check("rst_memreq",  {31'h0, mem_bus.mem_req_o}, 32'h0);
        check("rst_fault",   {31'h0, core_fault}, 32'h0);
        check("rst_rd",      core_rd, 32'h0);
        check("rst_addr",    mem_bus.mem_addr_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // LW, ready in the request cycle
        access(1'b0, LDST_W, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        check("lw_stalls", a_stalls, 32'd1);
        check("lw_rd",     a_rd, 32'hDEAD_BEEF);
        check("lw_be",     a_be, 32'hF);
        check("lw_addr",   a_addr, 32'h0000_0100);
        check("lw_we",     a_we, 32'h0);

        // LB / LBU at offset 3, ready in third WAIT cycle
        access(1'b0, LDST_B, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3);
        check("lb_stalls", a_stalls, 32'd4);
        check("lb_rd",     a_rd, 32'hFFFF_FF80);
        check("lb_be",     a_be, 32'h8);
        check("lb_fault",  a_faults, 32'd0);
        access(1'b0, LDST_BU, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3);
        check("lbu_stalls", a_stalls, 32'd4);
        check("lbu_rd",     a_rd, 32'h0000_0080);

        // Halfword loads
        access(1'b0, LDST_H, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 1);
        check("lh_hi_stalls", a_stalls, 32'd2);
        check("lh_hi_rd",     a_rd, 32'hFFFF_8001);
        access(1'b0, LDST_HU, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 0);
        check("lhu_hi_rd",    a_rd, 32'h0000_8001);
        access(1'b0, LDST_H, 32'h0000_0100, 32'h0, 32'h8001_7FFF, 0);
        check("lh_lo_rd",     a_rd, 32'h0000_7FFF);

        // SH at 0x202
        access(1'b1, LDST_H, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 0);
        check("sh_be",   a_be, 32'hC);
        check("sh_wd",   a_wd, 32'hABCD_ABCD);
        check("sh_addr", a_addr, 32'h0000_0200);
        check("sh_we",   a_we, 32'h1);
        check("sh_rd",   a_rd, 32'h0);

        // SB at 0x301
        access(1'b1, LDST_B, 32'h0000_0301, 32'h1234_56A5, 32'h0, 0);
        check("sb_be", a_be, 32'h2);
        check("sb_wd", a_wd, 32'hA5A5_A5A5);

        // Timeout: memory never answers
        access(1'b0, LDST_W, 32'h0000_0500, 32'h0, 32'h1111_1111, -1);
        check("to_reqs",   a_reqs, 32'd5);
        check("to_stalls", a_stalls, 32'd5);
        check("to_faults", a_faults, 32'd1);
        check("to_rd",     a_rd, 32'h0);
        access(1'b0, LDST_W, 32'h0000_0504, 32'h0, 32'h2222_3333, 0);
        check("after_to_stalls", a_stalls, 32'd1);
        check("after_to_rd",     a_rd, 32'h2222_3333);

        // Reset asserted in WAIT
        @(posedge clk); #1;
        core_req  = 1'b1;
        core_size = LDST_W;
        core_addr = 32'h0000_0400;
        mem_bus.mem_ready_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstw_req_before", {31'h0, mem_bus.mem_req_o}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rstw_req",   {31'h0, mem_bus.mem_req_o}, 32'h0);
        check("rstw_stall", {31'h0, core_stall}, 32'h0);
        core_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstw_fault1", {31'h0, core_fault}, 32'h0);
        @(negedge clk);
        check("rstw_fault2", {31'h0, core_fault}, 32'h0);
        access(1'b0, LDST_W, 32'h0000_0408, 32'h0, 32'h0BAD_F00D, 0);
        check("rstw_next_stalls", a_stalls, 32'd1);
        check("rstw_next_rd",     a_rd, 32'h0BAD_F00D);

        // LW at misaligned address 0x101
        access(1'b0, LDST_W, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0);
`ifdef MISALIGN_CHECK_EN
        check("mis_reqs",   a_reqs, 32'd0);
        check("mis_stalls", a_stalls, 32'd1);
        check("mis_faults", a_faults, 32'd1);
        check("mis_rd",     a_rd, 32'h0);
        check("mis_addr",   a_addr, 32'h0);
`else
        check("mis_reqs",   a_reqs, 32'd1);
        check("mis_stalls", a_stalls, 32'd1);
        check("mis_faults", a_faults, 32'd0);
        check("mis_rd",     a_rd, 32'hCAFE_F00D);
        check("mis_addr",   a_addr, 32'h0000_0100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
